// File: rtl/hnoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hnoc_pkg
// Description : Shared constants, packet layout and round-robin helpers for
//               the 4-PE hierarchical tree fabric.
// Revision    : 1.0 - initial release
// ============================================================================
package hnoc_pkg;

    localparam int NUM_PE    = 4;
    localparam int ADDR_W    = $clog2(NUM_PE);
    localparam int DATA_W    = 32;
    localparam int TOTAL_W   = DATA_W + ADDR_W;
    localparam int NUM_PORTS = 3;

    // Port indices shared by every node (inputs and outputs alike)
    localparam logic [1:0] CHILD0 = 2'd0;
    localparam logic [1:0] CHILD1 = 2'd1;
    localparam logic [1:0] PARENT = 2'd2;

    typedef enum logic {
        LEVEL_LEAF = 1'b0,
        LEVEL_ROOT = 1'b1
    } node_level_e;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] payload;
    } packet_t;

    // (base + offset) modulo the port count, for offsets 0..NUM_PORTS-1
    function automatic logic [1:0] rr_wrap(input logic [1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return 2'(sum);
    endfunction

    // One-hot grant: first requester found starting at the pointer position
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] gnt;
        logic [1:0] idx;
        gnt = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = rr_wrap(ptr, k);
            if (req[idx]) begin
                gnt = 3'b001 << idx;
            end
        end
        return gnt;
    endfunction

    // Pointer value that places the just-granted input last in priority
    function automatic logic [1:0] rr_next(input logic [2:0] gnt);
        logic [1:0] nxt;
        nxt = 2'd0;
        if (gnt[0]) begin
            nxt = 2'd1;
        end else if (gnt[1]) begin
            nxt = 2'd2;
        end
        return nxt;
    endfunction

endpackage : hnoc_pkg
`default_nettype wire

// File: rtl/hnoc_node.sv
`default_nettype none
// ============================================================================
// Module      : hnoc_node
// Description : 3-port tree router (child0, child1, parent). Each output has
//               a round-robin arbiter and a 1-entry output register that can
//               drain and refill in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module hnoc_node
    import hnoc_pkg::*;
#(
    parameter int          DATA_WIDTH = DATA_W,
    parameter node_level_e NODE_LEVEL = LEVEL_LEAF,
    parameter logic        NODE_ID    = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    // child0 side
    input  logic [DATA_WIDTH+ADDR_W-1:0] i_c0_data,
    input  logic                         i_c0_valid,
    output logic                         o_c0_ready,
    output logic [DATA_WIDTH+ADDR_W-1:0] o_c0_data,
    output logic                         o_c0_valid,
    input  logic                         i_c0_ready,
    // child1 side
    input  logic [DATA_WIDTH+ADDR_W-1:0] i_c1_data,
    input  logic                         i_c1_valid,
    output logic                         o_c1_ready,
    output logic [DATA_WIDTH+ADDR_W-1:0] o_c1_data,
    output logic                         o_c1_valid,
    input  logic                         i_c1_ready,
    // parent side
    input  logic [DATA_WIDTH+ADDR_W-1:0] i_p_data,
    input  logic                         i_p_valid,
    output logic                         o_p_ready,
    output logic [DATA_WIDTH+ADDR_W-1:0] o_p_data,
    output logic                         o_p_valid,
    input  logic                         i_p_ready
);

    localparam int TW = DATA_WIDTH + ADDR_W;

    logic [TW-1:0]          w_in_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_in_valid;
    logic [NUM_PORTS-1:0]   w_drain;
    logic [1:0]             w_tgt     [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_req     [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_gnt     [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_sel     [NUM_PORTS];
    logic [TW-1:0]          w_mux     [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_load;
    logic                   w_acc_c0;
    logic                   w_acc_c1;
    logic                   w_acc_p;

    logic [NUM_PORTS-1:0]   r_full;
    logic [TW-1:0]          r_data    [NUM_PORTS];
    logic [1:0]             r_ptr     [NUM_PORTS];

    assign w_in_data[CHILD0] = i_c0_data;
    assign w_in_data[CHILD1] = i_c1_data;
    assign w_in_data[PARENT] = i_p_data;
    assign w_in_valid        = {i_p_valid, i_c1_valid, i_c0_valid};
    assign w_drain           = {i_p_ready, i_c1_ready, i_c0_ready};

    // Output port selected by each input's destination address
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_tgt[i] = PARENT;
            if (NODE_LEVEL == LEVEL_ROOT) begin
                w_tgt[i] = w_in_data[i][TW-1] ? CHILD1 : CHILD0;
            end else if (w_in_data[i][TW-1] == NODE_ID) begin
                w_tgt[i] = w_in_data[i][TW-2] ? CHILD1 : CHILD0;
            end
        end
    end

    // Per-output requests, round-robin grant, and the ready-select mask
    // (an output with no requester exposes its free state to idle inputs)
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[o][i] = w_in_valid[i] && (w_tgt[i] == 2'(o));
            end
            w_gnt[o] = rr_pick(w_req[o], r_ptr[o]);
            w_mux[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_sel[o][i] = w_gnt[o][i] || ((w_req[o] == '0) && (w_tgt[i] == 2'(o)));
                if (w_gnt[o][i]) begin
                    w_mux[o] = w_in_data[i];
                end
            end
        end
    end

    // Output register can take a packet when empty or draining this cycle.
    // Kept as scalars so ready paths between nodes stay acyclic per signal.
    assign w_acc_c0 = !r_full[CHILD0] || i_c0_ready;
    assign w_acc_c1 = !r_full[CHILD1] || i_c1_ready;
    assign w_acc_p  = !r_full[PARENT] || i_p_ready;

    assign w_load = {(|w_req[PARENT]) && w_acc_p,
                     (|w_req[CHILD1]) && w_acc_c1,
                     (|w_req[CHILD0]) && w_acc_c0};

    assign o_c0_ready = (w_sel[CHILD0][CHILD0] && w_acc_c0) ||
                        (w_sel[CHILD1][CHILD0] && w_acc_c1) ||
                        (w_sel[PARENT][CHILD0] && w_acc_p);
    assign o_c1_ready = (w_sel[CHILD0][CHILD1] && w_acc_c0) ||
                        (w_sel[CHILD1][CHILD1] && w_acc_c1) ||
                        (w_sel[PARENT][CHILD1] && w_acc_p);
    assign o_p_ready  = (w_sel[CHILD0][PARENT] && w_acc_c0) ||
                        (w_sel[CHILD1][PARENT] && w_acc_c1) ||
                        (w_sel[PARENT][PARENT] && w_acc_p);

    // Output registers and arbiter pointers: load the winner, else drain
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_full[o] <= 1'b0;
                r_data[o] <= '0;
                r_ptr[o]  <= 2'd0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_load[o]) begin
                    r_full[o] <= 1'b1;
                    r_data[o] <= w_mux[o];
                    r_ptr[o]  <= rr_next(w_gnt[o]);
                end else if (w_drain[o]) begin
                    r_full[o] <= 1'b0;
                end
            end
        end
    end

    assign o_c0_valid = r_full[CHILD0];
    assign o_c0_data  = r_data[CHILD0];
    assign o_c1_valid = r_full[CHILD1];
    assign o_c1_data  = r_data[CHILD1];
    assign o_p_valid  = r_full[PARENT];
    assign o_p_data   = r_data[PARENT];

endmodule : hnoc_node
`default_nettype wire

// File: rtl/hnoc4_fabric.sv
`default_nettype none
// ============================================================================
// Module      : hnoc4_fabric
// Description : 4-PE hierarchical NoC: two leaf routers (PE0/PE1, PE2/PE3)
//               joined by one root router. One cycle of latency per node.
// Revision    : 1.0 - initial release
// ============================================================================
module hnoc4_fabric
    import hnoc_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_PES     = 4,
    localparam int ADDR_WIDTH  = $clog2(NUM_PES),
    localparam int TOTAL_WIDTH = DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [TOTAL_WIDTH-1:0] i_pe_data0,
    input  logic                   i_pe_data_valid0,
    output logic                   o_pe_data_ready0,
    output logic [TOTAL_WIDTH-1:0] o_pe_data0,
    output logic                   o_pe_data_valid0,
    input  logic                   i_pe_data_ready0,
    input  logic [TOTAL_WIDTH-1:0] i_pe_data1,
    input  logic                   i_pe_data_valid1,
    output logic                   o_pe_data_ready1,
    output logic [TOTAL_WIDTH-1:0] o_pe_data1,
    output logic                   o_pe_data_valid1,
    input  logic                   i_pe_data_ready1,
    input  logic [TOTAL_WIDTH-1:0] i_pe_data2,
    input  logic                   i_pe_data_valid2,
    output logic                   o_pe_data_ready2,
    output logic [TOTAL_WIDTH-1:0] o_pe_data2,
    output logic                   o_pe_data_valid2,
    input  logic                   i_pe_data_ready2,
    input  logic [TOTAL_WIDTH-1:0] i_pe_data3,
    input  logic                   i_pe_data_valid3,
    output logic                   o_pe_data_ready3,
    output logic [TOTAL_WIDTH-1:0] o_pe_data3,
    output logic                   o_pe_data_valid3,
    input  logic                   i_pe_data_ready3
);

    if (NUM_PES != NUM_PE) begin : g_bad_num_pes
        $error("hnoc4_fabric supports exactly 4 PEs");
    end

    // Leaf <-> root links
    logic [TOTAL_WIDTH-1:0] w_l0_up_data, w_l1_up_data, w_r_dn0_data, w_r_dn1_data;
    logic                   w_l0_up_valid, w_l1_up_valid, w_r_dn0_valid, w_r_dn1_valid;
    logic                   w_l0_up_ready, w_l1_up_ready, w_r_dn0_ready, w_r_dn1_ready;
    logic                   w_rdy0, w_rdy1, w_rdy2, w_rdy3;
    // Root parent output never carries traffic
    logic [TOTAL_WIDTH-1:0] w_root_unused_data;
    logic                   w_root_unused_valid;
    logic                   w_root_unused_ready;

    hnoc_node #(
        .DATA_WIDTH (DATA_WIDTH),
        .NODE_LEVEL (LEVEL_LEAF),
        .NODE_ID    (1'b0)
    ) u_leaf0 (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_c0_data  (i_pe_data0),
        .i_c0_valid (i_pe_data_valid0),
        .o_c0_ready (w_rdy0),
        .o_c0_data  (o_pe_data0),
        .o_c0_valid (o_pe_data_valid0),
        .i_c0_ready (i_pe_data_ready0),
        .i_c1_data  (i_pe_data1),
        .i_c1_valid (i_pe_data_valid1),
        .o_c1_ready (w_rdy1),
        .o_c1_data  (o_pe_data1),
        .o_c1_valid (o_pe_data_valid1),
        .i_c1_ready (i_pe_data_ready1),
        .i_p_data   (w_r_dn0_data),
        .i_p_valid  (w_r_dn0_valid),
        .o_p_ready  (w_r_dn0_ready),
        .o_p_data   (w_l0_up_data),
        .o_p_valid  (w_l0_up_valid),
        .i_p_ready  (w_l0_up_ready)
    );

    hnoc_node #(
        .DATA_WIDTH (DATA_WIDTH),
        .NODE_LEVEL (LEVEL_LEAF),
        .NODE_ID    (1'b1)
    ) u_leaf1 (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_c0_data  (i_pe_data2),
        .i_c0_valid (i_pe_data_valid2),
        .o_c0_ready (w_rdy2),
        .o_c0_data  (o_pe_data2),
        .o_c0_valid (o_pe_data_valid2),
        .i_c0_ready (i_pe_data_ready2),
        .i_c1_data  (i_pe_data3),
        .i_c1_valid (i_pe_data_valid3),
        .o_c1_ready (w_rdy3),
        .o_c1_data  (o_pe_data3),
        .o_c1_valid (o_pe_data_valid3),
        .i_c1_ready (i_pe_data_ready3),
        .i_p_data   (w_r_dn1_data),
        .i_p_valid  (w_r_dn1_valid),
        .o_p_ready  (w_r_dn1_ready),
        .o_p_data   (w_l1_up_data),
        .o_p_valid  (w_l1_up_valid),
        .i_p_ready  (w_l1_up_ready)
    );

    hnoc_node #(
        .DATA_WIDTH (DATA_WIDTH),
        .NODE_LEVEL (LEVEL_ROOT),
        .NODE_ID    (1'b0)
    ) u_root (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_c0_data  (w_l0_up_data),
        .i_c0_valid (w_l0_up_valid),
        .o_c0_ready (w_l0_up_ready),
        .o_c0_data  (w_r_dn0_data),
        .o_c0_valid (w_r_dn0_valid),
        .i_c0_ready (w_r_dn0_ready),
        .i_c1_data  (w_l1_up_data),
        .i_c1_valid (w_l1_up_valid),
        .o_c1_ready (w_l1_up_ready),
        .o_c1_data  (w_r_dn1_data),
        .o_c1_valid (w_r_dn1_valid),
        .i_c1_ready (w_r_dn1_ready),
        .i_p_data   ('0),
        .i_p_valid  (1'b0),
        .o_p_ready  (w_root_unused_ready),
        .o_p_data   (w_root_unused_data),
        .o_p_valid  (w_root_unused_valid),
        .i_p_ready  (1'b0)
    );

    // PE-facing readies are held low while reset is asserted
    assign o_pe_data_ready0 = i_reset && w_rdy0;
    assign o_pe_data_ready1 = i_reset && w_rdy1;
    assign o_pe_data_ready2 = i_reset && w_rdy2;
    assign o_pe_data_ready3 = i_reset && w_rdy3;

endmodule : hnoc4_fabric
`default_nettype wire

// File: tb/tb_hnoc4_fabric.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hnoc4_fabric
// Description : Directed self-checking bench for the 4-PE tree fabric.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hnoc4_fabric;

    localparam int TW = 34;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] pe_data  [4];
    logic [3:0]    pe_vld;
    logic [3:0]    pe_rdy;
    logic [TW-1:0] out_data [4];
    logic [3:0]    out_vld;
    logic [3:0]    sink_rdy;

    int n_checks = 0;
    int n_errors = 0;

    logic [TW-1:0] txq [4][$];
    logic [TW-1:0] rxq [4][$];
    logic [3:0]    fire;
    logic [3:0]    held;
    logic [TW-1:0] held_data [4];
    int            stab_err;
    int            rx_total;

    hnoc4_fabric dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_pe_data0       (pe_data[0]),
        .i_pe_data_valid0 (pe_vld[0]),
        .o_pe_data_ready0 (pe_rdy[0]),
        .o_pe_data0       (out_data[0]),
        .o_pe_data_valid0 (out_vld[0]),
        .i_pe_data_ready0 (sink_rdy[0]),
        .i_pe_data1       (pe_data[1]),
        .i_pe_data_valid1 (pe_vld[1]),
        .o_pe_data_ready1 (pe_rdy[1]),
        .o_pe_data1       (out_data[1]),
        .o_pe_data_valid1 (out_vld[1]),
        .i_pe_data_ready1 (sink_rdy[1]),
        .i_pe_data2       (pe_data[2]),
        .i_pe_data_valid2 (pe_vld[2]),
        .o_pe_data_ready2 (pe_rdy[2]),
        .o_pe_data2       (out_data[2]),
        .o_pe_data_valid2 (out_vld[2]),
        .i_pe_data_ready2 (sink_rdy[2]),
        .i_pe_data3       (pe_data[3]),
        .i_pe_data_valid3 (pe_vld[3]),
        .o_pe_data_ready3 (pe_rdy[3]),
        .o_pe_data3       (out_data[3]),
        .o_pe_data_valid3 (out_vld[3]),
        .i_pe_data_ready3 (sink_rdy[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packet = {dest, src[15:0], seq[15:0]}
    function automatic logic [TW-1:0] pkt(input int src, input int dst, input int seq);
        logic [1:0]  d;
        logic [15:0] s;
        logic [15:0] q;
        d = 2'(dst);
        s = 16'(src);
        q = 16'(seq);
        return {d, s, q};
    endfunction

    task automatic refresh();
        for (int n = 0; n < 4; n++) begin
            if (txq[n].size() > 0) begin
                pe_vld[n]  = 1'b1;
                pe_data[n] = txq[n][0];
            end else begin
                pe_vld[n]  = 1'b0;
                pe_data[n] = '0;
            end
        end
    endtask

    // One clock: sample handshakes at the negedge, advance sources after the posedge
    task automatic cycle();
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            fire[n] = pe_vld[n] & pe_rdy[n];
            if (held[n] && (!out_vld[n] || (out_data[n] !== held_data[n]))) stab_err++;
            held[n]      = out_vld[n] & ~sink_rdy[n];
            held_data[n] = out_data[n];
            if (out_vld[n] && sink_rdy[n]) begin
                rxq[n].push_back(out_data[n]);
                rx_total++;
            end
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (fire[n]) void'(txq[n].pop_front());
        end
        refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int idle;
        int k;
        idle = 0;
        k = 0;
        while (idle < 6 && k < budget) begin
            cycle();
            k++;
            if (txq[0].size() + txq[1].size() + txq[2].size() + txq[3].size() == 0 && out_vld == 4'b0)
                idle++;
            else
                idle = 0;
        end
        check({tag, " drained in budget"}, 64'(k < budget), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int sink, input int src, input int count);
        int got_cnt;
        int bad;
        logic [TW-1:0] e;
        got_cnt = 0;
        bad = 0;
        for (int j = 0; j < rxq[sink].size(); j++) begin
            e = rxq[sink][j];
            if (e[31:16] == 16'(src)) begin
                if (e[33:32] != 2'(sink) || e[15:0] != 16'(got_cnt)) bad++;
                got_cnt++;
            end
        end
        check({tag, " count"}, 64'(got_cnt), 64'(count));
        check({tag, " order"}, 64'(bad), 64'd0);
    endtask

    task automatic clear_all();
        for (int n = 0; n < 4; n++) begin
            txq[n].delete();
            rxq[n].delete();
        end
        held     = '0;
        stab_err = 0;
        rx_total = 0;
    endtask

    initial begin
        int same_pairs;
        logic [TW-1:0] any_data;
        rst_n    = 1'b0;
        pe_vld   = '0;
        sink_rdy = 4'hF;
        for (int n = 0; n < 4; n++) pe_data[n] = '0;
        clear_all();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(pe_rdy), 64'd0);
        check("reset valid", 64'(out_vld), 64'd0);
        check("reset data1", 64'(out_data[1]), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle ready after reset", 64'(pe_rdy), 64'hF);

        // Single local packet PE0 -> PE1
        @(posedge clk); #1;
        pe_data[0] = {2'd1, 32'hDEADBEEF};
        pe_vld[0]  = 1'b1;
        @(negedge clk);
        check("local ready0", 64'(pe_rdy[0]), 64'd1);
        @(posedge clk); #1;
        pe_vld[0]  = 1'b0;
        pe_data[0] = '0;
        @(negedge clk);
        check("local valid", 64'(out_vld), 64'b0010);
        check("local data1", 64'(out_data[1]), 64'h1DEADBEEF);
        @(negedge clk);
        check("local one-shot", 64'(out_vld), 64'd0);

        // Cross-tree packet PE0 -> PE3 (three nodes)
        @(posedge clk); #1;
        pe_data[0] = {2'd3, 32'h12345678};
        pe_vld[0]  = 1'b1;
        @(negedge clk);
        check("cross ready0", 64'(pe_rdy[0]), 64'd1);
        @(posedge clk); #1;
        pe_vld[0]  = 1'b0;
        pe_data[0] = '0;
        @(negedge clk);
        check("cross hop1 quiet", 64'(out_vld), 64'd0);
        @(negedge clk);
        check("cross hop2 quiet", 64'(out_vld), 64'd0);
        @(negedge clk);
        check("cross valid", 64'(out_vld), 64'b1000);
        check("cross data3", 64'(out_data[3]), 64'h312345678);
        @(negedge clk);
        check("cross one-shot", 64'(out_vld), 64'd0);

        // Neighbour pattern: PE i -> PE (i+1)%4, 100 packets each
        @(posedge clk); #1;
        clear_all();
        for (int n = 0; n < 4; n++)
            for (int s = 0; s < 100; s++) txq[n].push_back(pkt(n, (n + 1) % 4, s));
        refresh();
        #1 check("neighbour all ready", 64'(pe_rdy), 64'hF);
        drain("neighbour", 400);
        check("neighbour total", 64'(rx_total), 64'd400);
        for (int d = 0; d < 4; d++) check_stream($sformatf("neighbour sink%0d", d), d, (d + 3) % 4, 100);

        // Contention: PE0 and PE2 both stream to PE1
        clear_all();
        for (int s = 0; s < 50; s++) begin
            txq[0].push_back(pkt(0, 1, s));
            txq[2].push_back(pkt(2, 1, s));
        end
        refresh();
        drain("contention", 400);
        check_stream("contention src0", 1, 0, 50);
        check_stream("contention src2", 1, 2, 50);
        same_pairs = 0;
        for (int j = 1; j < rxq[1].size(); j++)
            if (rxq[1][j][31:16] == rxq[1][j-1][31:16]) same_pairs++;
        check("contention alternation", 64'(same_pairs), 64'd2);

        // Backpressure: PE1 stalls 20 cycles while PE0 streams to it
        clear_all();
        for (int s = 0; s < 30; s++) txq[0].push_back(pkt(0, 1, s));
        sink_rdy[1] = 1'b0;
        refresh();
        repeat (20) cycle();
        check("bp ready0 low", 64'(pe_rdy[0]), 64'd0);
        check("bp hold valid", 64'(out_vld[1]), 64'd1);
        check("bp hold data", 64'(out_data[1]), 64'(pkt(0, 1, 0)));
        check("bp nothing delivered", 64'(rxq[1].size()), 64'd0);
        sink_rdy[1] = 1'b1;
        drain("backpressure", 400);
        check_stream("bp sink1", 1, 0, 30);
        check("bp stable while held", 64'(stab_err), 64'd0);

        // Reset in the middle of traffic
        clear_all();
        for (int n = 0; n < 4; n++)
            for (int s = 0; s < 20; s++) txq[n].push_back(pkt(n, (n + 1) % 4, s));
        refresh();
        repeat (6) cycle();
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++) txq[n].delete();
        refresh();
        @(negedge clk);
        check("mid reset ready", 64'(pe_rdy), 64'd0);
        @(negedge clk);
        check("mid reset valid", 64'(out_vld), 64'd0);
        any_data = out_data[0] | out_data[1] | out_data[2] | out_data[3];
        check("mid reset data", 64'(any_data), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("post reset idle ready", 64'(pe_rdy), 64'hF);
        clear_all();
        txq[1].push_back(pkt(1, 2, 77));
        refresh();
        drain("post reset", 100);
        check("post reset total", 64'(rx_total), 64'd1);
        check("post reset packet", 64'((rxq[2].size() > 0) ? rxq[2][0] : '0), 64'(pkt(1, 2, 77)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hnoc4_fabric
`default_nettype wire
